// File: rtl/cla64_bist_if.sv
// cla64_bist_if: control/status bundle between a test controller and the
// cla64 self-test engine.
//   start         controller -> bist  one-cycle run request
//   inject_fault  controller -> bist  flip sum bit 0 at compare (only with
//                                     CLA64_BIST_INJECT_EN defined)
//   busy, done, pass                  run status (registered)
//   vector_count, error_count         per-run counters
//   fail_a/b/cin/sum                  first failing vector capture
`timescale 1ns/1ps

interface cla64_bist_if;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 32;

  logic          start;
`ifdef CLA64_BIST_INJECT_EN
  logic          inject_fault;
`endif
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] vector_count;
  logic [CW-1:0] error_count;
  logic [DW-1:0] fail_a;
  logic [DW-1:0] fail_b;
  logic          fail_cin;
  logic [DW-1:0] fail_sum;

  // Test controller side.
  modport master (
`ifdef CLA64_BIST_INJECT_EN
    output inject_fault,
`endif
    output start,
    input  busy,
    input  done,
    input  pass,
    input  vector_count,
    input  error_count,
    input  fail_a,
    input  fail_b,
    input  fail_cin,
    input  fail_sum
  );

  // Self-test engine side.
  modport slave (
`ifdef CLA64_BIST_INJECT_EN
    input  inject_fault,
`endif
    input  start,
    output busy,
    output done,
    output pass,
    output vector_count,
    output error_count,
    output fail_a,
    output fail_b,
    output fail_cin,
    output fail_sum
  );

endinterface

// File: rtl/cla64_bist.sv
// cla64_bist: built-in self-test for the 64-bit carry-lookahead adder cla64.
// Two Galois LFSRs generate operands; each vector is applied for one settle
// cycle (APPLY) and compared against a behavioural a+b+cin in CHECK.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      cla64_bist_if.slave (start, status, counters, first-fail capture)
// Optional feature macro: CLA64_BIST_INJECT_EN adds inject_fault, which
// inverts bit 0 of the observed sum during CHECK.
// Also contains cla64 (sum, a, b, cin): three-level 4-bit-group CLA.
`timescale 1ns/1ps

module cla64 (
  output logic [63:0] sum,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin
);
  localparam int unsigned W  = 64;
  localparam int unsigned NG = W / 4;   // 4-bit groups
  localparam int unsigned NS = NG / 4;  // 16-bit sections

  // Group generate over four (g, p) pairs.
  function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Carries into positions 0..3 of a 4-wide block, all from ci in parallel.
  function automatic logic [3:0] carries4(input logic [3:0] g, input logic [3:0] p,
                                          input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Bit -> group -> section lookahead tree; carry-out is not needed.
  function automatic logic [W-1:0] cla_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
    logic [W-1:0]  p;
    logic [W-1:0]  g;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NS-1:0] sp;
    logic [NS-1:0] sg;
    logic [NS-1:0] sc;
    logic [NG-1:0] gc;
    logic [W-1:0]  c;
    p = x ^ y;
    g = x & y;
    for (int unsigned j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = gen4(g[4*j +: 4], p[4*j +: 4]);
    end
    for (int unsigned k = 0; k < NS; k++) begin
      sp[k] = &gp[4*k +: 4];
      sg[k] = gen4(gg[4*k +: 4], gp[4*k +: 4]);
    end
    sc = carries4(sg, sp, ci);
    for (int unsigned k = 0; k < NS; k++) begin
      gc[4*k +: 4] = carries4(gg[4*k +: 4], gp[4*k +: 4], sc[k]);
    end
    for (int unsigned j = 0; j < NG; j++) begin
      c[4*j +: 4] = carries4(g[4*j +: 4], p[4*j +: 4], gc[j]);
    end
    return p ^ c;
  endfunction

  assign sum = cla_sum(a, b, cin);

endmodule

module cla64_bist #(
  parameter int unsigned N_VECTORS = 64,
  parameter logic [63:0] SEED      = 64'h0123_4567_89AB_CDEF
) (
  input logic         clk,
  input logic         reset_n,
  cla64_bist_if.slave bus
);
  localparam int unsigned W  = 64;
  localparam int unsigned CW = 32;
  localparam logic [W-1:0]  TAPS     = 64'hD800_0000_0000_0000;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_VECTORS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [W-1:0]  lfa;
  logic [W-1:0]  lfb;
  logic [CW-1:0] vec_cnt;
  logic [CW-1:0] err_cnt;
  logic [W-1:0]  fail_a_q;
  logic [W-1:0]  fail_b_q;
  logic          fail_cin_q;
  logic [W-1:0]  fail_sum_q;
  logic          first_fail;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;

  logic          cin_c;
  logic [W-1:0]  dut_sum;
  logic [W-1:0]  obs_sum_c;
  logic [W-1:0]  ref_sum_c;
  logic          mismatch_c;
  logic          last_c;
  logic          load_c;
  logic          check_c;
  logic [CW-1:0] err_sat_c;
  logic [CW-1:0] err_nxt_c;

  // Right-shifting Galois LFSR step.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] cur);
    return {1'b0, cur[W-1:1]} ^ (cur[0] ? TAPS : {W{1'b0}});
  endfunction

  // Operands come straight from the LFSR registers; cin mixes both ends.
  assign cin_c = lfa[0] ^ lfb[W-1];

  cla64 u_cla64 (
    .sum (dut_sum),
    .a   (lfa),
    .b   (lfb),
    .cin (cin_c)
  );

`ifdef CLA64_BIST_INJECT_EN
  assign obs_sum_c = dut_sum ^ {{(W-1){1'b0}}, bus.inject_fault & (state == S_CHECK)};
`else
  assign obs_sum_c = dut_sum;
`endif

  // Behavioural reference and compare.
  assign ref_sum_c  = lfa + lfb + W'(cin_c);
  assign mismatch_c = (obs_sum_c != ref_sum_c);
  assign last_c     = (vec_cnt == LAST_IDX);
  assign err_sat_c  = (err_cnt == {CW{1'b1}}) ? err_cnt : err_cnt + CW'(1);
  assign err_nxt_c  = mismatch_c ? err_sat_c : err_cnt;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    check_c   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          load_c    = 1'b1;
          state_nxt = S_APPLY;
        end
      end
      S_APPLY: state_nxt = S_CHECK;
      S_CHECK: begin
        check_c   = 1'b1;
        state_nxt = last_c ? S_DONE : S_APPLY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Generators, counters and first-fail capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfa        <= SEED;
      lfb        <= ~SEED;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_cin_q <= 1'b0;
      fail_sum_q <= '0;
      first_fail <= 1'b0;
      pass_q     <= 1'b0;
    end else if (load_c) begin
      lfa        <= SEED;
      lfb        <= ~SEED;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_cin_q <= 1'b0;
      fail_sum_q <= '0;
      first_fail <= 1'b0;
      pass_q     <= 1'b0;
    end else if (check_c) begin
      vec_cnt <= vec_cnt + CW'(1);
      err_cnt <= err_nxt_c;
      if (mismatch_c && !first_fail) begin
        fail_a_q   <= lfa;
        fail_b_q   <= lfb;
        fail_cin_q <= cin_c;
        fail_sum_q <= obs_sum_c;
        first_fail <= 1'b1;
      end
      lfa <= lfsr_step(lfa);
      lfb <= lfsr_step(lfb);
      if (last_c) pass_q <= (err_nxt_c == '0);
    end
  end

  // Registered status, decoded from the next state so it tracks the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == S_APPLY) || (state_nxt == S_CHECK);
      done_q <= (state_nxt == S_DONE);
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.vector_count = vec_cnt;
  assign bus.error_count  = err_cnt;
  assign bus.fail_a       = fail_a_q;
  assign bus.fail_b       = fail_b_q;
  assign bus.fail_cin     = fail_cin_q;
  assign bus.fail_sum     = fail_sum_q;

endmodule

// File: tb/tb_cla64_bist.sv
// Directed self-checking bench for cla64_bist: reset, default run with a
// per-vector operand/sum model, restart handshake, mid-run reset, a
// single-vector instance and (with CLA64_BIST_INJECT_EN) fault injection.
`timescale 1ns/1ps

module tb_cla64_bist;
  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  cla64_bist_if bus  ();
  cla64_bist_if bus1 ();

  cla64_bist #(.N_VECTORS(64), .SEED(SEED)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  cla64_bist #(.N_VECTORS(1),  .SEED(SEED)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  always #5 clk = ~clk;

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return {1'b0, v[63:1]} ^ (v[0] ? TAPS : 64'h0);
  endfunction

  // One-cycle start; returns #1 after the sampling edge.
  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) bus1.start = 1'b1; else bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus1.start = 1'b0;
  endtask

  // Edges until done is seen (-1 if the budget expires).
  task automatic wait_done(input bit which, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget && cycles < 0; i++) begin
      @(posedge clk);
      #1;
      if ((which ? bus1.done : bus.done) === 1'b1) cycles = i;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: busy/done/pass=%b%b%b want 000", bus.busy, bus.done, bus.pass);
    end
    n_cmp++;
    if (bus.vector_count !== 32'd0 || bus.error_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_counts: vc=%0d ec=%0d want 0/0", bus.vector_count, bus.error_count);
    end
    n_cmp++;
    if ({bus.fail_a, bus.fail_b, bus.fail_cin, bus.fail_sum} !== 193'd0) begin
      n_bad++; $display("FAIL reset_fail: a=%h b=%h cin=%b sum=%h want 0", bus.fail_a, bus.fail_b, bus.fail_cin, bus.fail_sum);
    end
    n_cmp++;
    if (dut.lfa !== SEED || dut.lfb !== ~SEED) begin
      n_bad++; $display("FAIL reset_lfsr: lfa=%h lfb=%h want %h/%h", dut.lfa, dut.lfb, SEED, ~SEED);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_default_run();
    logic [63:0] ma;
    logic [63:0] mb;
    logic        mc;
    int          cyc;
    pulse_start(1'b0);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_bad++; $display("FAIL start_latency: busy=%b done=%b want 1/0", bus.busy, bus.done);
    end
    // First vector: a=SEED, b=~SEED, cin = SEED[0] ^ ~SEED[63] = 1 ^ 1 = 0,
    // so the sum is all ones.
    n_cmp++;
    if (dut.lfa !== 64'h0123_4567_89AB_CDEF || dut.lfb !== 64'hFEDC_BA98_7654_3210) begin
      n_bad++; $display("FAIL first_operands: a=%h b=%h", dut.lfa, dut.lfb);
    end
    n_cmp++;
    if (dut.cin_c !== 1'b0) begin
      n_bad++; $display("FAIL first_cin: got %b want 0", dut.cin_c);
    end
    n_cmp++;
    if (dut.dut_sum !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_bad++; $display("FAIL first_sum: got %h want ffffffffffffffff", dut.dut_sum);
    end
    ma  = SEED;
    mb  = ~SEED;
    cyc = -1;
    for (int i = 1; i <= 200 && cyc < 0; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) begin
        n_bad++; $display("FAIL busy_done_overlap: edge %0d", i);
      end
      if (i == 2) begin
        n_cmp++;
        if (bus.vector_count !== 32'd1) begin
          n_bad++; $display("FAIL first_check_count: got %0d want 1", bus.vector_count);
        end
      end
      if (bus.done === 1'b1) cyc = i;
      else if (i % 2 == 0) begin
        ma = lfsr_step(ma);
        mb = lfsr_step(mb);
        mc = ma[0] ^ mb[63];
        n_cmp++;
        if (dut.lfa !== ma || dut.lfb !== mb || dut.cin_c !== mc || dut.dut_sum !== ma + mb + 64'(mc)) begin
          n_bad++; $display("FAIL vector_%0d: a=%h b=%h sum=%h want a=%h b=%h sum=%h",
                            i / 2, dut.lfa, dut.lfb, dut.dut_sum, ma, mb, ma + mb + 64'(mc));
        end
      end
    end
    n_cmp++;
    if (cyc !== 128) begin
      n_bad++; $display("FAIL run_length: done after %0d edges want 128", cyc);
    end
    n_cmp++;
    if (bus.vector_count !== 32'd64 || bus.error_count !== 32'd0 || bus.pass !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL run_result: vc=%0d ec=%0d pass=%b busy=%b want 64/0/1/0",
                        bus.vector_count, bus.error_count, bus.pass, bus.busy);
    end
    n_cmp++;
    if ({bus.fail_a, bus.fail_b, bus.fail_cin, bus.fail_sum} !== 193'd0) begin
      n_bad++; $display("FAIL run_fail_regs: a=%h b=%h sum=%h want 0", bus.fail_a, bus.fail_b, bus.fail_sum);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    pulse_start(1'b0);
    n_cmp++;
    if (bus.vector_count !== 32'd0 || bus.done !== 1'b0 || bus.pass !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL restart_clear: vc=%0d done=%b pass=%b busy=%b want 0/0/0/1",
                        bus.vector_count, bus.done, bus.pass, bus.busy);
    end
    repeat (19) @(posedge clk);
    pulse_start(1'b0);
    n_cmp++;
    if (bus.vector_count !== 32'd10 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL midrun_start: vc=%0d busy=%b want 10/1", bus.vector_count, bus.busy);
    end
    wait_done(1'b0, 200, cyc);
    n_cmp++;
    if (cyc < 0 || cyc + 20 !== 128) begin
      n_bad++; $display("FAIL rerun_length: done after %0d edges want 128", cyc < 0 ? cyc : cyc + 20);
    end
    n_cmp++;
    if (bus.vector_count !== 32'd64 || bus.error_count !== 32'd0 || bus.pass !== 1'b1) begin
      n_bad++; $display("FAIL rerun_result: vc=%0d ec=%0d pass=%b want 64/0/1",
                        bus.vector_count, bus.error_count, bus.pass);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    pulse_start(1'b0);
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.vector_count !== 32'd10) begin
      n_bad++; $display("FAIL pre_reset_count: got %0d want 10", bus.vector_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
        bus.vector_count !== 32'd0 || bus.error_count !== 32'd0) begin
      n_bad++; $display("FAIL async_reset: busy=%b done=%b pass=%b vc=%0d ec=%0d want all 0",
                        bus.busy, bus.done, bus.pass, bus.vector_count, bus.error_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, 200, cyc);
    n_cmp++;
    if (cyc !== 128 || bus.vector_count !== 32'd64 || bus.pass !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_run: edges=%0d vc=%0d pass=%b want 128/64/1",
                        cyc, bus.vector_count, bus.pass);
    end
  endtask

  task automatic test_single_vector();
    int cyc;
    pulse_start(1'b1);
    wait_done(1'b1, 10, cyc);
    n_cmp++;
    if (cyc !== 2) begin
      n_bad++; $display("FAIL single_length: done after %0d edges want 2", cyc);
    end
    n_cmp++;
    if (bus1.vector_count !== 32'd1 || bus1.error_count !== 32'd0 || bus1.pass !== 1'b1) begin
      n_bad++; $display("FAIL single_result: vc=%0d ec=%0d pass=%b want 1/0/1",
                        bus1.vector_count, bus1.error_count, bus1.pass);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus1.vector_count !== 32'd1) begin
      n_bad++; $display("FAIL single_hold: done=%b busy=%b vc=%0d want 1/0/1",
                        bus1.done, bus1.busy, bus1.vector_count);
    end
  endtask

`ifdef CLA64_BIST_INJECT_EN
  task automatic test_inject();
    int cyc;
    bus.inject_fault = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, 200, cyc);
    bus.inject_fault = 1'b0;
    n_cmp++;
    if (cyc !== 128 || bus.error_count !== 32'd64 || bus.pass !== 1'b0) begin
      n_bad++; $display("FAIL inject_counts: edges=%0d ec=%0d pass=%b want 128/64/0",
                        cyc, bus.error_count, bus.pass);
    end
    // First vector sum is all ones; bit 0 flipped gives ...FFFE.
    n_cmp++;
    if (bus.fail_a !== SEED || bus.fail_b !== ~SEED || bus.fail_cin !== 1'b0 ||
        bus.fail_sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_bad++; $display("FAIL inject_capture: a=%h b=%h cin=%b sum=%h want %h/%h/0/fffffffffffffffe",
                        bus.fail_a, bus.fail_b, bus.fail_cin, bus.fail_sum, SEED, ~SEED);
    end
  endtask
`endif

  initial begin
    bus.start  = 1'b0;
    bus1.start = 1'b0;
`ifdef CLA64_BIST_INJECT_EN
    bus.inject_fault  = 1'b0;
    bus1.inject_fault = 1'b0;
`endif
    test_reset();
    test_default_run();
    test_back_to_back();
    test_mid_reset();
    test_single_vector();
`ifdef CLA64_BIST_INJECT_EN
    test_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
